// File: rtl/clock_display_scan.sv
// Multiplexed 4-digit common-anode 7-segment scanner for HH.MM / MM.SS pages.
// Binary fields are snapshotted once per frame, BCD-split, and scanned one digit per slot.

module clock_display_field (
  input  logic [5:0] val,
  input  logic [5:0] lim,
  output logic [6:0] tens_seg,
  output logic [6:0] ones_seg
);
  logic [5:0] rem;
  logic [2:0] tens;

  function automatic logic [6:0] seg_of(input logic [5:0] d);
    case (d)
      6'd0:    seg_of = 7'h40;
      6'd1:    seg_of = 7'h79;
      6'd2:    seg_of = 7'h24;
      6'd3:    seg_of = 7'h30;
      6'd4:    seg_of = 7'h19;
      6'd5:    seg_of = 7'h12;
      6'd6:    seg_of = 7'h02;
      6'd7:    seg_of = 7'h78;
      6'd8:    seg_of = 7'h00;
      6'd9:    seg_of = 7'h10;
      default: seg_of = 7'h7F;
    endcase
  endfunction

  // Restoring compare/subtract by 40, 20, 10 covers 0..63 without a divider
  always_comb begin
    rem  = val;
    tens = 3'd0;
    if (rem >= 6'd40) begin
      rem  = rem - 6'd40;
      tens = tens + 3'd4;
    end
    if (rem >= 6'd20) begin
      rem  = rem - 6'd20;
      tens = tens + 3'd2;
    end
    if (rem >= 6'd10) begin
      rem  = rem - 6'd10;
      tens = tens + 3'd1;
    end
  end

  always_comb begin
    if (val > lim) begin
      tens_seg = 7'h3F;
      ones_seg = 7'h3F;
    end else begin
      tens_seg = seg_of({3'b000, tens});
      ones_seg = seg_of(rem);
    end
  end
endmodule

module clock_display_scan #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] hour,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  input  logic       page,
  input  logic [1:0] blink_sel,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);
  localparam int NUM_FIELDS = 2;
  localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [RW-1:0] R_TC = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] B_TC = BW'(BLINK_DIV - 1);

  logic [RW-1:0] rcnt;
  logic [BW-1:0] bcnt;
  logic [1:0]    idx;
  logic          phase;
  logic          r_tc;

  // Field 1 is the left pair (digits 3,2), field 0 the right pair (digits 1,0)
  logic [NUM_FIELDS-1:0][5:0] snap;
  logic [NUM_FIELDS-1:0][5:0] lim;
  logic [NUM_FIELDS-1:0][6:0] tens_seg;
  logic [NUM_FIELDS-1:0][6:0] ones_seg;

  logic [6:0] dcode;
  logic       blank;

  assign r_tc = (rcnt == R_TC);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rcnt <= '0;
      idx  <= 2'd0;
      snap <= '0;
    end else if (r_tc) begin
      rcnt <= '0;
      idx  <= idx + 2'd1;
      if (idx == 2'd3) begin
        snap[1] <= page ? min : hour;
        snap[0] <= page ? sec : min;
      end
    end else begin
      rcnt <= rcnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bcnt  <= '0;
      phase <= 1'b0;
    end else if (bcnt == B_TC) begin
      bcnt  <= '0;
      phase <= ~phase;
    end else begin
      bcnt <= bcnt + 1'b1;
    end
  end

  // Range limit follows the live page, so a page flip may dash the old snapshot for one frame
  assign lim[1] = page ? 6'd59 : 6'd23;
  assign lim[0] = 6'd59;

  for (genvar f = 0; f < NUM_FIELDS; f++) begin : g_field
    clock_display_field u_field (
      .val      (snap[f]),
      .lim      (lim[f]),
      .tens_seg (tens_seg[f]),
      .ones_seg (ones_seg[f])
    );
  end

  assign dcode = idx[0] ? tens_seg[idx[1]] : ones_seg[idx[1]];
  assign blank = blink_sel[idx[1]] && !phase;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an  <= 4'hF;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      if (blank) begin
        an  <= 4'hF;
        seg <= 7'h7F;
      end else begin
        an  <= ~(4'b0001 << idx);
        seg <= dcode;
      end
      dp <= !((idx == 2'd2) && phase);
    end
  end
endmodule

// File: tb/tb_clock_display_scan.sv
// Bench for clock_display_scan: edge-count reference model checked every cycle, plus fixed scenarios.

module tb_clock_display_scan;
  localparam int R = 4;
  localparam int B = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] hour = '0, min = '0, sec = '0;
  logic       page = 1'b0;
  logic [1:0] blink_sel = '0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int compared = 0;
  int mismatched = 0;
  int e = 0;

  clock_display_scan #(.REFRESH_DIV(R), .BLINK_DIV(B)) dut (
    .clk(clk), .rst_n(rst_n), .hour(hour), .min(min), .sec(sec),
    .page(page), .blink_sel(blink_sel), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  logic [6:0] segtab [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  // Model: n = edges taken since reset release; slot, phase and frame follow by division
  int         n = 0;
  bit         chk = 1'b0;
  int         s_left = 0, s_right = 0;
  logic [3:0] e_an = 4'hF;
  logic [6:0] e_seg = 7'h7F;
  logic       e_dp = 1'b1;

  always @(posedge clk) begin : model
    int idx, ph, v, lim, d;
    if (!rst_n) begin
      n = 0; s_left = 0; s_right = 0;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      chk = 1'b1;
    end else begin
      idx = (n / R) % 4;
      ph  = (n / B) % 2;
      v   = (idx >= 2) ? s_left : s_right;
      lim = (idx >= 2 && !page) ? 23 : 59;
      d   = (idx % 2 == 1) ? v / 10 : v % 10;
      if (blink_sel[idx / 2] && ph == 0) begin
        e_an = 4'hF; e_seg = 7'h7F;
      end else begin
        e_an  = 4'hF ^ (4'b0001 << idx);
        e_seg = (v > lim) ? 7'h3F : segtab[d];
      end
      e_dp = !(idx == 2 && ph == 1);
      if (n % (4 * R) == 4 * R - 1) begin
        s_left  = page ? int'(min) : int'(hour);
        s_right = page ? int'(sec) : int'(min);
      end
      n++;
    end
  end

  always @(negedge clk) begin
    if (chk) begin
      compared++;
      if (an !== e_an || seg !== e_seg || dp !== e_dp) begin
        mismatched++;
        $display("FAIL scan t=%0t got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                 $time, an, seg, dp, e_an, e_seg, e_dp);
      end
    end
  end

  task automatic lit(input string nm, input logic [3:0] wan, input logic [6:0] wseg, input logic wdp);
    compared++;
    if (an !== wan || seg !== wseg || dp !== wdp) begin
      mismatched++;
      $display("FAIL %s got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
               nm, an, seg, dp, wan, wseg, wdp);
    end
  endtask

  // Inputs are applied before calling; releases reset on a falling edge
  task automatic do_reset();
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    e = 0;
  endtask

  // Advance to just after the k-th rising edge since reset release
  task automatic at(input int k);
    repeat (k - e) @(negedge clk);
    e = k;
    #1;
  endtask

  initial begin
    // T1: first frame shows snapshot 0, then 12:34
    hour = 6'd12; min = 6'd34; page = 1'b0; blink_sel = 2'b00;
    do_reset();
    at(1);  lit("t1_first", 4'b1110, 7'h40, 1'b1);
    at(9);  lit("t1_first_d2", 4'b1011, 7'h40, 1'b1);
    at(17); lit("t1_d0", 4'b1110, 7'h19, 1'b1);
    at(21); lit("t1_d1", 4'b1101, 7'h30, 1'b1);
    at(25); lit("t1_d2_dp", 4'b1011, 7'h24, 1'b0);
    at(29); lit("t1_d3", 4'b0111, 7'h79, 1'b1);

    // T2: MM.SS page
    page = 1'b1; min = 6'd5; sec = 6'd59;
    do_reset();
    at(17); lit("t2_d0", 4'b1110, 7'h10, 1'b1);
    at(21); lit("t2_d1", 4'b1101, 7'h12, 1'b1);
    at(29); lit("t2_d3", 4'b0111, 7'h40, 1'b1);

    // T3: out-of-range dashes, then back in range
    page = 1'b0; hour = 6'd24; min = 6'd60;
    do_reset();
    at(17); lit("t3_min_dash", 4'b1110, 7'h3F, 1'b1);
    at(29); lit("t3_hour_dash", 4'b0111, 7'h3F, 1'b1);
    hour = 6'd23; min = 6'd0;
    at(41); lit("t3_h_ones", 4'b1011, 7'h30, 1'b1);
    at(45); lit("t3_h_tens", 4'b0111, 7'h24, 1'b1);

    // T4/T5: left field blinks, dp flashes in digit-2 slots
    hour = 6'd12; min = 6'd34; blink_sel = 2'b10;
    do_reset();
    at(1);  lit("t4_right_lit", 4'b1110, 7'h40, 1'b1);
    at(9);  lit("t4_d2_blank", 4'b1111, 7'h7F, 1'b1);
    at(13); lit("t4_d3_blank", 4'b1111, 7'h7F, 1'b1);
    at(25); lit("t4_d2_on", 4'b1011, 7'h24, 1'b0);
    at(29); lit("t4_d3_on", 4'b0111, 7'h79, 1'b1);
    at(41); lit("t5_d2_blank", 4'b1111, 7'h7F, 1'b1);
    at(57); lit("t5_dp_on", 4'b1011, 7'h24, 1'b0);

    // T6: input change mid-frame is deferred, then mid-frame reset
    blink_sel = 2'b00; min = 6'd34;
    do_reset();
    at(18); min = 6'd56;
    at(21); lit("t6_no_tear", 4'b1101, 7'h30, 1'b1);
    at(33); lit("t6_new_ones", 4'b1110, 7'h02, 1'b1);
    at(37); lit("t6_new_tens", 4'b1101, 7'h12, 1'b1);
    at(38); rst_n = 1'b0;
    @(negedge clk); #1;
    lit("t6_reset", 4'b1111, 7'h7F, 1'b1);

    // Random inputs, page flips, blinking and occasional resets
    do_reset();
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 29) == 0) hour = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 29) == 0) min = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 29) == 0) sec = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 99) == 0) page = ~page;
      if ($urandom_range(0, 149) == 0) blink_sel = 2'($urandom_range(0, 3));
      rst_n = ($urandom_range(0, 799) != 0);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
